// File: rtl/f_le_arbiter.sv
// Round-robin arbiter sharing one f_less_or_equal comparator between N_REQ
// requesters, with an optional lock for back-to-back compares by one owner.
module f_le_arbiter #(
  parameter int FLEN     = 64,
  parameter int N_REQ    = 4,
  parameter int LOCK_MAX = 4,
  localparam int IDW     = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int CW      = $clog2(LOCK_MAX + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ-1:0][FLEN-1:0] req_a,
  input  logic [N_REQ-1:0][FLEN-1:0] req_b,
  input  logic [N_REQ-1:0]           req_lock,
  output logic [N_REQ-1:0]           req_ready,
  output logic [N_REQ-1:0]           rsp_valid,
  output logic                       rsp_res,
  output logic                       rsp_err,
  output logic [FLEN-1:0]            f_le_a,
  output logic [FLEN-1:0]            f_le_b,
  input  logic                       f_le_res,
  input  logic                       f_le_err,
  output logic                       busy,
  output logic [IDW-1:0]             owner
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t          state, state_nxt;
  logic [IDW-1:0]  rr_ptr, rr_nxt;
  logic [IDW-1:0]  owner_nxt;
  logic [CW-1:0]   idle_cnt, idle_nxt;
  logic            grant_vld;
  logic [IDW-1:0]  grant_idx;
  logic [IDW-1:0]  cand;

  function automatic logic [IDW-1:0] inc_idx(input logic [IDW-1:0] i);
    return (int'(i) == N_REQ - 1) ? '0 : i + 1'b1;
  endfunction

  // Winner: the owner alone while locked, otherwise the first valid request
  // at or after rr_ptr. Scanning from the far end lets the nearest one win.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    if (state == LOCKED) begin
      grant_vld = req_valid[owner];
      grant_idx = owner;
    end else begin
      for (int k = N_REQ - 1; k >= 0; k--) begin
        cand = IDW'((int'(rr_ptr) + k) % N_REQ);
        if (req_valid[cand]) begin
          grant_vld = 1'b1;
          grant_idx = cand;
        end
      end
    end
  end

  assign req_ready = grant_vld ? (N_REQ'(1) << grant_idx) : '0;
  assign f_le_a    = grant_vld ? req_a[grant_idx] : '0;
  assign f_le_b    = grant_vld ? req_b[grant_idx] : '0;
  assign busy      = (state != IDLE) || (|rsp_valid);

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    idle_nxt  = idle_cnt;
    rr_nxt    = rr_ptr;
    if (grant_vld) rr_nxt = inc_idx(grant_idx);
    case (state)
      IDLE: begin
        if (grant_vld && req_lock[grant_idx]) begin
          state_nxt = LOCKED;
          owner_nxt = grant_idx;
          idle_nxt  = '0;
        end
      end
      LOCKED: begin
        if (grant_vld) begin
          idle_nxt = '0;
          if (!req_lock[owner]) begin
            state_nxt = IDLE;
            owner_nxt = '0;
          end
        end else if (idle_cnt == CW'(LOCK_MAX - 1)) begin
          // Owner went quiet too long: hand the comparator back to the ring.
          state_nxt = IDLE;
          owner_nxt = '0;
          idle_nxt  = '0;
          rr_nxt    = inc_idx(owner);
        end else begin
          idle_nxt = idle_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      idle_cnt  <= '0;
      rsp_valid <= '0;
      rsp_res   <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      rr_ptr    <= rr_nxt;
      owner     <= owner_nxt;
      idle_cnt  <= idle_nxt;
      rsp_valid <= req_ready;
      if (grant_vld) begin
        rsp_res <= f_le_res;
        rsp_err <= f_le_err;
      end
    end
  end

endmodule

// File: tb/tb_f_le_arbiter.sv
// Directed bench for f_le_arbiter: reset, round-robin, lock burst, forced
// release, NaN error pass-through and reset during a lock.
module tb_f_le_arbiter;

  localparam int FLEN = 64;
  localparam int N    = 4;
  localparam logic [63:0] ONE = 64'h3FF0000000000000;
  localparam logic [63:0] TWO = 64'h4000000000000000;
  localparam logic [63:0] QNAN = 64'h7FF8000000000000;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [N-1:0]           req_valid = '0;
  logic [N-1:0][FLEN-1:0] req_a = '0;
  logic [N-1:0][FLEN-1:0] req_b = '0;
  logic [N-1:0]           req_lock = '0;
  logic [N-1:0]           req_ready, rsp_valid;
  logic                   rsp_res, rsp_err, busy;
  logic [FLEN-1:0]        f_le_a, f_le_b;
  logic                   f_le_res, f_le_err;
  logic [1:0]             owner;

  int n_cmp = 0;
  int n_bad = 0;

  f_le_arbiter #(.FLEN(FLEN), .N_REQ(N), .LOCK_MAX(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_lock(req_lock), .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_res(rsp_res), .rsp_err(rsp_err), .f_le_a(f_le_a), .f_le_b(f_le_b),
    .f_le_res(f_le_res), .f_le_err(f_le_err), .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  // Behavioural comparator: IEEE <= on doubles, NaN operand flags error.
  function automatic logic is_nan(input logic [63:0] x);
    return (&x[62:52]) && (|x[51:0]);
  endfunction
  assign f_le_err = is_nan(f_le_a) || is_nan(f_le_b);
  assign f_le_res = !f_le_err && ($bitstoreal(f_le_a) <= $bitstoreal(f_le_b));

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = '0;
    req_lock  = '0;
    req_a     = '0;
    req_b     = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
    n_cmp++; if (rsp_valid !== 4'b0000) begin n_bad++; $display("FAIL reset_rsp_valid got=%b exp=0000", rsp_valid); end
    n_cmp++; if ({rsp_res, rsp_err} !== 2'b00) begin n_bad++; $display("FAIL reset_res_err got=%b exp=00", {rsp_res, rsp_err}); end
    n_cmp++; if (f_le_a !== '0 || f_le_b !== '0) begin n_bad++; $display("FAIL reset_operands got=%h/%h exp=0/0", f_le_a, f_le_b); end
    n_cmp++; if (busy !== 1'b0 || owner !== 2'd0) begin n_bad++; $display("FAIL reset_busy_owner got=%b/%0d exp=0/0", busy, owner); end
  endtask

  task automatic test_single();
    do_reset();
    req_valid = 4'b0010;
    req_a[1]  = ONE;
    req_b[1]  = TWO;
    #1;
    n_cmp++; if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL single_ready got=%b exp=0010", req_ready); end
    n_cmp++; if (f_le_a !== ONE || f_le_b !== TWO) begin n_bad++; $display("FAIL single_operands got=%h/%h exp=%h/%h", f_le_a, f_le_b, ONE, TWO); end
    cyc();
    idle_inputs();
    #1;
    n_cmp++; if (rsp_valid !== 4'b0010) begin n_bad++; $display("FAIL single_rsp_valid got=%b exp=0010", rsp_valid); end
    n_cmp++; if (rsp_res !== 1'b1 || rsp_err !== 1'b0) begin n_bad++; $display("FAIL single_res_err got=%b/%b exp=1/0", rsp_res, rsp_err); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy got=%b exp=1", busy); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_grant [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                  4'b0001, 4'b0010, 4'b0100, 4'b1000};
    do_reset();
    req_valid = 4'b1111;
    #1;
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (req_ready !== exp_grant[i]) begin n_bad++; $display("FAIL rr_grant[%0d] got=%b exp=%b", i, req_ready, exp_grant[i]); end
      if (i > 0) begin
        n_cmp++; if (rsp_valid !== exp_grant[i-1]) begin n_bad++; $display("FAIL rr_rsp[%0d] got=%b exp=%b", i, rsp_valid, exp_grant[i-1]); end
      end
      cyc();
    end
    idle_inputs();
    #1;
    n_cmp++; if (rsp_valid !== 4'b1000) begin n_bad++; $display("FAIL rr_rsp_last got=%b exp=1000", rsp_valid); end
  endtask

  task automatic test_lock_burst();
    logic [2:0] locks = 3'b011;  // bit k is req_lock for compare k
    do_reset();
    req_valid = 4'b0010;         // one grant to requester 1 moves rr_ptr to 2
    cyc();
    for (int k = 0; k < 3; k++) begin
      req_valid   = 4'b0101;
      req_lock[2] = locks[k];
      req_a[2]    = TWO;
      req_b[2]    = ONE;
      #1;
      n_cmp++; if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL lock_grant[%0d] got=%b exp=0100", k, req_ready); end
      if (k > 0) begin
        n_cmp++; if (owner !== 2'd2) begin n_bad++; $display("FAIL lock_owner[%0d] got=%0d exp=2", k, owner); end
      end
      cyc();
    end
    req_valid = 4'b0001;
    req_lock  = '0;
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL lock_after got=%b exp=0001", req_ready); end
    n_cmp++; if (owner !== 2'd0) begin n_bad++; $display("FAIL lock_owner_released got=%0d exp=0", owner); end
    n_cmp++; if (rsp_valid !== 4'b0100 || rsp_res !== 1'b0) begin n_bad++; $display("FAIL lock_last_rsp got=%b/%b exp=0100/0", rsp_valid, rsp_res); end
  endtask

  task automatic test_forced_release();
    do_reset();
    req_valid   = 4'b1000;
    req_lock[3] = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 4'b1000) begin n_bad++; $display("FAIL force_acquire got=%b exp=1000", req_ready); end
    cyc();
    req_valid = 4'b0010;         // owner 3 goes quiet, requester 1 waits
    req_lock  = '0;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++; if (req_ready !== 4'b0000 || owner !== 2'd3) begin n_bad++; $display("FAIL force_wait[%0d] got=%b/%0d exp=0000/3", i, req_ready, owner); end
      cyc();
    end
    n_cmp++; if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL force_grant got=%b exp=0010", req_ready); end
    n_cmp++; if (owner !== 2'd0) begin n_bad++; $display("FAIL force_owner got=%0d exp=0", owner); end
  endtask

  task automatic test_error();
    do_reset();
    req_valid = 4'b0001;
    req_a[0]  = QNAN;
    req_b[0]  = ONE;
    cyc();
    idle_inputs();
    #1;
    n_cmp++; if (rsp_valid !== 4'b0001) begin n_bad++; $display("FAIL err_rsp_valid got=%b exp=0001", rsp_valid); end
    n_cmp++; if (rsp_err !== 1'b1 || rsp_res !== 1'b0) begin n_bad++; $display("FAIL err_res_err got=%b/%b exp=0/1", rsp_res, rsp_err); end
    cyc();
    n_cmp++; if (rsp_valid !== 4'b0000 || rsp_err !== 1'b1) begin n_bad++; $display("FAIL err_hold got=%b/%b exp=0000/1", rsp_valid, rsp_err); end
  endtask

  task automatic test_reset_mid_lock();
    do_reset();
    req_valid   = 4'b0010;
    req_lock[1] = 1'b1;
    cyc();
    n_cmp++; if (owner !== 2'd1 || busy !== 1'b1) begin n_bad++; $display("FAIL rml_locked got=%0d/%b exp=1/1", owner, busy); end
    rst = 1'b1;                  // owner is granted again this cycle, then reset hits
    cyc();
    rst = 1'b0;
    idle_inputs();
    #1;
    n_cmp++; if (rsp_valid !== 4'b0000) begin n_bad++; $display("FAIL rml_rsp got=%b exp=0000", rsp_valid); end
    n_cmp++; if (owner !== 2'd0 || busy !== 1'b0) begin n_bad++; $display("FAIL rml_owner_busy got=%0d/%b exp=0/0", owner, busy); end
    req_valid = 4'b0011;
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL rml_first got=%b exp=0001", req_ready); end
    cyc();
    n_cmp++; if (req_ready !== 4'b0010 || rsp_valid !== 4'b0001) begin n_bad++; $display("FAIL rml_second got=%b/%b exp=0010/0001", req_ready, rsp_valid); end
    idle_inputs();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_lock_burst();
    test_forced_release();
    test_error();
    test_reset_mid_lock();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/f_le_arbiter.md
Name: f_le_arbiter

Overview:
- Shares one external f_less_or_equal comparator between N_REQ requesters, such as several float-sort FSMs.
- Arbitration is round-robin, one comparison per cycle.
- A lock option lets a requester issue back-to-back comparisons without interleaving, e.g. the 3 compares of a sort.
- Each result is registered and returned to its requester one cycle after grant.
- FLEN comes from the shared cvw config header.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- LOCK_MAX, 4, idle cycles an owner may hold the lock without requesting before forced release (>=1).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- req_valid  in  N_REQ  per-requester compare request
- req_a  in  [N_REQ][FLEN]  operand a per requester
- req_b  in  [N_REQ][FLEN]  operand b per requester
- req_lock  in  N_REQ  keep ownership after this grant
- req_ready  out  N_REQ  one-hot grant, combinational, same cycle as request accepted
- rsp_valid  out  N_REQ  one-hot, registered; result for the requester granted in the previous cycle
- rsp_res  out  1  registered f_le_res of that grant
- rsp_err  out  1  registered f_le_err of that grant
- f_le_a  out  FLEN  comparator operand a
- f_le_b  out  FLEN  comparator operand b
- f_le_res  in  1  comparator result (a <= b), combinational
- f_le_err  in  1  comparator error (NaN operand)
- busy  out  1  state != IDLE or any rsp_valid pending
- owner  out  $clog2(N_REQ)  current lock owner; 0 when unlocked

Behaviour:
- Reset: rst is synchronous and active-high on clk.
  - state=IDLE, rr_ptr=0, owner=0, idle_cnt=0.
  - rsp_valid=0, rsp_res=0, rsp_err=0.
  - With no valid requests, req_ready=0 and f_le_a=f_le_b=0.
- States:
  - IDLE (unlocked).
  - LOCKED (owner holds comparator).
- Winner selection, combinational, each cycle:
  - IDLE: first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... mod N_REQ.
  - LOCKED: only owner is eligible; other requests wait, their req_ready=0.
- Grant cycle for winner w:
  - req_ready[w]=1.
  - f_le_a=req_a[w], f_le_b=req_b[w].
  - At clock edge: rsp_valid<=onehot(w), rsp_res<=f_le_res, rsp_err<=f_le_err.
  - At the same edge, rr_ptr<=(w+1) mod N_REQ.
- No grant: rsp_valid<=0 next cycle; rsp_res/rsp_err hold their previous values.
- Latency: exactly 1 cycle from grant to rsp_valid. Throughput is 1 grant per cycle.
- Requesters must hold req_a/req_b/req_lock stable while req_valid=1 and req_ready=0.
- Lock acquire: grant in IDLE with req_lock[w]=1 -> LOCKED, owner<=w, idle_cnt<=0.
- In LOCKED:
  - Owner grant with req_lock=1: stay LOCKED, idle_cnt<=0.
  - Owner grant with req_lock=0: -> IDLE. rr_ptr advances past owner, so another requester gets the next cycle.
  - Cycle with req_valid[owner]=0: idle_cnt++.
  - When idle_cnt reaches LOCK_MAX-1 on a non-requesting cycle: forced -> IDLE, idle_cnt<=0, rr_ptr<=(owner+1) mod N_REQ.
- Simultaneous lock release and competing request: release takes effect at the edge. Competing requesters are arbitrated from the following cycle, never the same cycle.
- rsp_err is a pure pass-through of f_le_err. The arbiter does not interpret NaN.
- Reset mid-lock or with a response pending: next cycle is IDLE with rsp_valid=0. The pending response is dropped.
- Priority wrap: rr_ptr wraps N_REQ-1 -> 0.
- Single active requester with no lock: granted every cycle it requests.

Test Plan:
- Single requester, unlocked.
  - Stimulus: requester 1 asks 1.0 (64'h3FF0000000000000) <= 2.0 (64'h4000000000000000).
  - Response: req_ready=4'b0010 same cycle; next cycle rsp_valid=4'b0010, rsp_res=1, rsp_err=0.
- Round-robin fairness.
  - Stimulus: req_valid=4'b1111 held for 8 cycles from reset.
  - Response: grants 0,1,2,3,0,1,2,3; each rsp_valid one-hot 1 cycle after its grant.
- Lock burst.
  - Stimulus: requester 2 issues 3 compares with req_lock=1,1,0 while requester 0 requests continuously.
  - Response: grants 2,2,2 consecutively, then 0; owner=2 during the burst.
- Forced release.
  - Stimulus: LOCK_MAX=4; requester 3 acquires the lock, then drops req_valid; requester 1 is waiting.
  - Response: after 4 idle cycles state=IDLE; requester 1 is granted the next cycle.
- Error pass-through.
  - Stimulus: compare NaN (64'h7FF8000000000000) vs 1.0; comparator model returns res=0, err=1.
  - Response: rsp_err=1, rsp_res=0 on the response cycle.
- Reset mid-lock.
  - Stimulus: assert rst for 1 cycle during a lock owned by requester 1 with a response pending.
  - Response: rsp_valid=0, owner=0, busy=0.
  - Follow-up: requesters 0 and 1 both then request; requester 0 is granted first.
